// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    CONV_DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned sat_value(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned k = 0; k < digits; k++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble adjust for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit_c
);

  assign o_digit_c = (i_digit >= BCD_W'(ADJ_THRESH)) ? i_digit + BCD_W'(ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit packed BCD converter, one bit per clock,
// saturating at the largest displayable value and holding the last result.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [BIN_W-1:0]          i_bin_in,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [BCD_W*DIGITS-1:0]   o_bcd_out,
  output logic                      o_ovf
);

  localparam int unsigned ACC_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] SAT = BIN_W'(sat_value(DIGITS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic [ACC_W-1:0]   r_bcd;
  logic               r_ovf;

  logic [ACC_W-1:0]   w_adj;
  logic               w_over;

  assign w_over = (i_bin_in > SAT);

  // Per-digit adjust on the accumulator; digits never carry into each other.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit   (r_acc[g*BCD_W +: BCD_W]),
      .o_digit_c (w_adj[g*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bin      <= '0;
      r_acc      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin      <= w_over ? SAT : i_bin_in;
            r_ovf_pend <= w_over;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the adjusted accumulator is always 0 for saturated inputs.
          r_acc <= ACC_W'({w_adj, r_bin[BIN_W-1]});
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) r_state <= CONV_DONE;
        end
        CONV_DONE: begin
          r_bcd   <= r_acc;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_bcd_out = r_bcd;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, boundaries, saturation, busy
// rejection, mid-conversion reset and a randomized sweep against a decimal model.
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [19:0] bin   = '0;
  logic        busy, done, ovf;
  logic [23:0] bcd;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic        rst_q    = 1'b1;
  logic [23:0] prev_bcd = '0;

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_bin_in  (bin),
    .o_busy    (busy),
    .o_done    (done),
    .o_bcd_out (bcd),
    .o_ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  // bcd_out may only move on a done pulse or on a reset edge.
  always @(negedge clk) begin
    if (bcd !== prev_bcd) begin
      n_assert++;
      assert (done === 1'b1 || rst_q === 1'b1)
      else begin
        n_fail++;
        $error("FAIL bcd_stable: bcd_out changed %06h -> %06h without done/reset", prev_bcd, bcd);
      end
    end
    prev_bcd = bcd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [19:0] v);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 20'($urandom);
  endtask

  // Edges counted from acceptance until done is visible (bounded).
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = int'(busy);
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned s;
    logic [23:0] r;
    s = (v > 999999) ? 999999 : v;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  task automatic convert(input string tag, input logic [19:0] v,
                         input logic [23:0] exp_bcd, input logic exp_ovf);
    int lat, bc;
    launch(v);
    chk({tag, "_busy_set"}, 32'(busy), 32'd1);
    wait_done(0, lat, bc);
    chk({tag, "_latency"}, 32'(lat), 32'd21);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd21);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, n_done;
    logic [19:0] rv;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    chk("rst_bcd",  32'(bcd),  32'd0);
    rst = 1'b0;
    tick();

    convert("basic",   20'd123456,  24'h123456, 1'b0);
    convert("zero",    20'd0,       24'h000000, 1'b0);
    convert("max",     20'd999999,  24'h999999, 1'b0);
    convert("p100k",   20'd100000,  24'h100000, 1'b0);
    convert("ovf_max", 20'd1048575, 24'h999999, 1'b1);
    convert("after",   20'd42,      24'h000042, 1'b0);

    // Busy rejection, then re-start in the done cycle
    launch(20'd555555);
    repeat (4) tick();
    start = 1'b1;
    bin   = 20'd777777;
    tick();
    start = 1'b0;
    chk("rej_busy", 32'(busy), 32'd1);
    wait_done(5, lat, bc);
    chk("rej_latency", 32'(lat), 32'd21);
    chk("rej_bcd", 32'(bcd), 32'h555555);
    launch(20'd777777);
    chk("redo_busy", 32'(busy), 32'd1);
    chk("redo_done_clr", 32'(done), 32'd0);
    wait_done(0, lat, bc);
    chk("redo_latency", 32'(lat), 32'd21);
    chk("redo_bcd", 32'(bcd), 32'h777777);
    tick();

    convert("ovf_1m", 20'd1000000, 24'h999999, 1'b1);

    // Reset mid-conversion
    launch(20'd314159);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd",  32'(bcd),  32'd0);
    chk("midrst_ovf",  32'(ovf),  32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    n_done = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    convert("post_rst", 20'd271828, 24'h271828, 1'b0);

    // Reset wins over start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    bin   = 20'd1234;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_prio_idle", 32'(busy), 32'd0);

    // Randomized sweep against the decimal reference model
    for (int i = 0; i < 1000; i++) begin
      rv = 20'($urandom_range(0, 1048575));
      launch(rv);
      wait_done(0, lat, bc);
      chk("rand_latency", 32'(lat), 32'd21);
      chk("rand_bcd", 32'(bcd), 32'(ref_bcd(32'(rv))));
      chk("rand_ovf", 32'(ovf), 32'(rv > 20'd999999));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that turns a 20-bit unsigned count into six packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the six-digit seven-segment display driver and supplies that driver's 24-bit data bus. Digit 5 is in bits [23:20] and digit 0 is in bits [3:0]. The output holds the last completed result, so the display stays stable while a new conversion runs.

## Interface
- `BIN_W`, default 20: binary input width; must satisfy 2^BIN_W > 10^DIGITS − 1.
- `DIGITS`, default 6: number of BCD digits; output width is 4·DIGITS.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: conversion request; sampled only while idle.
- `bin_in`  in  BIN_W: unsigned value; captured on the edge that accepts `start`.
- `busy`  out  1: high from the edge after acceptance until the result edge.
- `done`  out  1: one-cycle pulse, coincident with the new `bcd_out`.
- `bcd_out`  out  4·DIGITS: packed BCD result, held between conversions.
- `ovf`  out  1: high if the last captured `bin_in` exceeded 10^DIGITS − 1; updated together with `bcd_out`.

## Operation
- Reset values: `busy`=0, `done`=0, `ovf`=0, `bcd_out`=0, state IDLE, bit counter 0, internal registers 0.
- States:
  - **IDLE**
    - If `start`=1: capture min(`bin_in`, 10^DIGITS − 1) into the shift register.
    - Record the overflow flag internally.
    - Clear the BCD accumulator and set counter=0.
    - Go to SHIFT with `busy`←1.
  - **SHIFT**
    - Every edge, in this order:
      - For each digit ≥ 5, add 3 (the adjust step).
      - Shift {BCD accumulator, binary register} left by one.
      - counter++.
    - When counter = BIN_W − 1 on this edge, go to CONV_DONE.
    - Exactly BIN_W shift edges occur.
  - **CONV_DONE**
    - `bcd_out` ← accumulator.
    - `ovf` ← recorded flag.
    - `done` ← 1 and `busy` ← 0.
    - Go to IDLE.
- `done` is cleared on every edge where it is not being set.
- Arithmetic:
  - The add-3 test and the add are per 4-bit digit.
  - The adjust never carries between digits; a digit is at most 9 before adjust and at most 12 after.
  - Saturation value is 10^DIGITS − 1, which is 999999 for the defaults.

## Timing
- Latency: if `start` is accepted on edge 0, shifts occur on edges 1…BIN_W and the result lands on edge BIN_W+1 (21 for the defaults).
- `done` and the new `bcd_out` are both visible in the cycle after that edge.
- Throughput: one conversion per BIN_W+2 cycles when `start` is held high continuously.
- `start` while `busy`=1 or in CONV_DONE is ignored; it is neither queued nor an error.
- `start` high in the cycle where `done`=1: FSM is in IDLE, so the request is accepted.
- `bin_in` changes after acceptance have no effect on the running conversion.
- `rst` mid-conversion: the conversion aborts, all outputs return to reset values on that edge, and no `done` is issued.
- `rst` has priority over `start` on the same edge.
- `bcd_out` never shows intermediate values; it changes only in CONV_DONE or on reset.

## Structure
- Shared package `bin2bcd_pkg`:
  - State enum: IDLE, SHIFT, CONV_DONE.
  - Constants `BCD_W` = 4 and `ADJ_THRESH` = 5.
  - Saturation constant derived from DIGITS.
- Sub-module `bcd_digit_adj`:
  - Purely combinational 4-bit add-3-if-≥5.
  - Instantiated DIGITS times in a generate loop on the accumulator.
- Counter width is clog2(BIN_W).
- The FSM, counter and shift/accumulator registers live in the top module.

## Test plan
- **Basic conversion:** reset, then `start` with `bin_in`=123456 → `done` pulses 21 cycles after acceptance; `bcd_out`=0x123456, `ovf`=0, `busy` high for exactly 21 cycles.
- **Boundaries:** `bin_in`=0 → `bcd_out`=0x000000; `bin_in`=999999 → 0x999999 with `ovf`=0; `bin_in`=100000 → 0x100000.
- **Overflow:** `bin_in`=1048575 → `bcd_out`=0x999999, `ovf`=1; a following `bin_in`=42 → 0x000042 with `ovf` back to 0.
- **Busy rejection:** start 555555, pulse `start` with 777777 at cycle 5 of busy → a single `done` with 0x555555; `start` re-asserted in the `done` cycle with 777777 → accepted, 0x777777 after 21 more cycles.
- **Reset mid-conversion:** `rst` at cycle 10 of a conversion of 314159 → next cycle `busy`=0, `bcd_out`=0, no `done`; a new start then converts correctly.
- **Random regression:** 1000 random values in 0…2^20−1 checked against a reference model with saturation, `bcd_out` monitored to confirm it is stable except on `done`.
